// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment glyph constants and digit-count limits for seven_seg_scan
package seven_seg_pkg;

    localparam int MIN_DIGITS = 2;
    localparam int MAX_DIGITS = 8;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex nibble to active-high 7-segment pattern
// Ports:
//   nibble_i  4-bit hex digit
//   seg_o     {g,f,e,d,c,b,a}, 1 = segment lit
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_0;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed hex 7-segment display scanner with frame-aligned value update
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank segments of leading zero digits).
// Ports:
//   clk          system clock, posedge
//   reset        asynchronous active-low reset
//   scan_in      slow divided clock level; each rising edge advances the digit
//   value        hex nibbles, digit 0 in [3:0]
//   value_valid  producer offers value/dp
//   value_ready  pending buffer empty, offer will be taken
//   dp           per-digit decimal point, captured with value
//   blank        turn all digits and dp off
//   an           one-hot digit enables (polarity per ACTIVE_LOW)
//   seg          {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//   dp_out       decimal point of the active digit (polarity per ACTIVE_LOW)
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_in,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out
);

    localparam int              IW       = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
            $error("seven_seg_scan: NUM_DIGITS out of range");
        end
    endgenerate

    logic                    sync1_q, sync2_q, prev_q;
    logic                    tick_q, tick_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic                    ready_q, ready_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;

    logic                    wrap, xfer;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   show;
    logic                    show_sel, dp_sel;
    logic [NUM_DIGITS-1:0]   an_act;
    logic [6:0]              seg_act;
    logic                    dp_act;

    // Tick is the registered rising edge of the synchronized scan level.
    assign tick_d = sync2_q & ~prev_q;

    always_comb begin
        wrap        = tick_q && (idx_q == LAST_IDX);
        xfer        = value_valid && ready_q;
        idx_d       = idx_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;

        if (tick_q) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        // Only swap the displayed frame as the scan returns to digit 0.
        if (wrap && pend_full_q) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end

        // ready_q implies pending was empty, so this never collides with the copy above;
        // a transfer on a wrap tick therefore waits a whole frame in pending.
        if (xfer) begin
            pend_d      = value;
            pend_dp_d   = dp;
            pend_full_d = 1'b1;
        end

        ready_d = ~pend_full_d;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nz_seen;

    // Walk down from the top digit; a digit is shown once any nibble at or above it is nonzero.
    always_comb begin
        nz_seen = 1'b0;
        show    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_seen = nz_seen | (|disp_q[i*4 +: 4]);
            show[i] = nz_seen | (i == 0);
        end
    end
`else
    assign show = '1;
`endif

    always_comb begin
        an_act   = '0;
        nibble   = '0;
        dp_sel   = 1'b0;
        show_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                an_act[i] = 1'b1;
                nibble    = disp_q[i*4 +: 4];
                dp_sel    = disp_dp_q[i];
                show_sel  = show[i];
            end
        end
        seg_act = show_sel ? glyph : 7'h00;
        dp_act  = dp_sel & ~blank;
        if (blank) begin
            an_act = '0;
        end
        an_d     = ACTIVE_LOW ? ~an_act  : an_act;
        seg_d    = ACTIVE_LOW ? ~seg_act : seg_act;
        dp_out_d = ACTIVE_LOW ? ~dp_act  : dp_act;
    end

    seg_decode u_seg_decode (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            tick_q      <= 1'b0;
            idx_q       <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            an_q        <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q       <= {7{ACTIVE_LOW}};
            dp_out_q    <= ACTIVE_LOW;
        end else begin
            sync1_q     <= scan_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign value_ready = ready_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp_out      = dp_out_q;

endmodule
